// File: rtl/io_pad_ctrl_pkg.sv
// Shared types and constants for the pad-control layer.
//   filt_mode_e     : per-channel input qualification mode.
//   MIN_SYNC_STAGES : smallest synchroniser depth the channels will build.
package io_pad_ctrl_pkg;

  typedef enum logic [1:0] {
    BYPASS   = 2'b00,
    SYNC     = 2'b01,
    DEBOUNCE = 2'b10,
    RSVD     = 2'b11
  } filt_mode_e;

  localparam int unsigned MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/io_pad_qual_ch.sv
// One pad channel's input qualification: synchroniser, debounce filter and
// rise/fall edge detect.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   pad_in_i     : raw pad input
//   mode_i       : filt_mode_e encoding (BYPASS / SYNC / DEBOUNCE / RSVD)
//   thresh_i     : debounce threshold (change accepted after thresh_i + 1
//                  consecutive differing clocks)
//   io_in_o      : qualified input to the core
//   rise_o/fall_o: one-cycle edge pulses of the qualified value
module io_pad_qual_ch
  import io_pad_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter logic        RST_VAL     = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pad_in_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] thresh_i,
  output logic             io_in_o,
  output logic             rise_o,
  output logic             fall_o
);

  // Depths below the minimum are clamped rather than built unsafe.
  localparam int unsigned STAGES =
    (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

  filt_mode_e        mode;
  logic [STAGES-1:0] sync_q;
  logic              sync;
  logic              filt_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              q;
  logic              prev_q;

  assign mode = filt_mode_e'(mode_i);
  assign sync = sync_q[STAGES-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pad_in_i};
    end
  end

  // Outside DEBOUNCE the filter shadows sync so entering DEBOUNCE never
  // produces a spurious change.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_q <= RST_VAL;
      cnt_q  <= '0;
    end else if (mode != DEBOUNCE) begin
      filt_q <= sync;
      cnt_q  <= '0;
    end else if (sync == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q >= thresh_i) begin
      filt_q <= sync;
      cnt_q  <= '0;
    end else if (cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Edges come from sync in BYPASS so the raw combinational path is never
  // used to build pulses.
  assign q = (mode == DEBOUNCE) ? filt_q : sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= RST_VAL;
    end else begin
      prev_q <= q;
    end
  end

  assign rise_o = q & ~prev_q;
  assign fall_o = ~q & prev_q;

  always_comb begin
    io_in_o = sync;
    case (mode)
      BYPASS:   io_in_o = pad_in_i;
      DEBOUNCE: io_in_o = filt_q;
      default:  io_in_o = sync;
    endcase
  end

endmodule

// File: rtl/io_pad_ctrl_gen.sv
// Pad-control layer between the core io_in/io_out/io_oe/pad_cfg vectors and
// the FPGA pad primitives, for N_IO channels.
//   clk_i, rst_i  : qualification clock, asynchronous active-high reset
//   pad_in_i      : raw pad inputs
//   io_out_i      : core output data
//   io_oe_i       : core output enables (1 = drive)
//   pad_cfg_i     : per-channel pad configuration, bit 0 = pull enable
//   filt_mode_i   : per-channel qualification mode (filt_mode_e)
//   filt_thresh_i : shared debounce threshold
//   io_in_o       : qualified inputs to the core
//   rise_o/fall_o : one-cycle edge pulses per channel
//   pad_out_o     : pad output data
//   pad_oen_o     : pad output enable, active-low
//   pad_pen_o     : pad pull enable, active-low
//   safe_o        : high during the post-reset window in which all pad
//                   drivers are forced off and pulls forced on
module io_pad_ctrl_gen
  import io_pad_ctrl_pkg::*;
#(
  parameter int unsigned     N_IO        = 48,
  parameter int unsigned     NBIT_PADCFG = 6,
  parameter int unsigned     SYNC_STAGES = 2,
  parameter int unsigned     CNT_W       = 8,
  parameter int unsigned     SAFE_CYCLES = 16,
  parameter logic [N_IO-1:0] IN_RST_VAL  = '1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [N_IO-1:0]                   pad_in_i,
  input  logic [N_IO-1:0]                   io_out_i,
  input  logic [N_IO-1:0]                   io_oe_i,
  input  logic [N_IO-1:0][NBIT_PADCFG-1:0]  pad_cfg_i,
  input  logic [N_IO-1:0][1:0]              filt_mode_i,
  input  logic [CNT_W-1:0]                  filt_thresh_i,
  output logic [N_IO-1:0]                   io_in_o,
  output logic [N_IO-1:0]                   rise_o,
  output logic [N_IO-1:0]                   fall_o,
  output logic [N_IO-1:0]                   pad_out_o,
  output logic [N_IO-1:0]                   pad_oen_o,
  output logic [N_IO-1:0]                   pad_pen_o,
  output logic                              safe_o
);

  logic safe;
  logic unused_cfg;

  for (genvar i = 0; i < N_IO; i++) begin : g_ch
    io_pad_qual_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .RST_VAL     (IN_RST_VAL[i])
    ) u_qual (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .pad_in_i (pad_in_i[i]),
      .mode_i   (filt_mode_i[i]),
      .thresh_i (filt_thresh_i),
      .io_in_o  (io_in_o[i]),
      .rise_o   (rise_o[i]),
      .fall_o   (fall_o[i])
    );
  end

  if (SAFE_CYCLES == 0) begin : g_no_safe
    assign safe = 1'b0;
  end else begin : g_safe
    localparam int unsigned     SAFE_W   = $clog2(SAFE_CYCLES + 1);
    localparam logic [SAFE_W-1:0] SAFE_MAX = SAFE_W'(SAFE_CYCLES);

    logic [SAFE_W-1:0] safe_cnt_q;

    // Saturating count; any reset restarts the window from zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        safe_cnt_q <= '0;
      end else if (safe_cnt_q != SAFE_MAX) begin
        safe_cnt_q <= safe_cnt_q + 1'b1;
      end
    end

    assign safe = (safe_cnt_q < SAFE_MAX);
  end

  assign safe_o = safe;

  always_comb begin
    pad_oen_o = '1;
    pad_out_o = '0;
    pad_pen_o = '0;
    if (!safe) begin
      pad_oen_o = ~io_oe_i;
      pad_out_o = io_out_i;
      for (int unsigned i = 0; i < N_IO; i++) begin
        pad_pen_o[i] = ~pad_cfg_i[i][0];
      end
    end
  end

  // Only bit 0 of each configuration word is consumed here.
  assign unused_cfg = ^pad_cfg_i;

endmodule

// File: tb/tb_io_pad_ctrl_gen.sv
module tb_io_pad_ctrl_gen;

  localparam int N = 48;
  localparam logic [N-1:0] ALL1 = '1;
  localparam logic [N-1:0] B0   = 48'd1;
  localparam logic [N-1:0] B5   = 48'd1 << 5;
  localparam logic [N-1:0] B7   = 48'd1 << 7;

  typedef struct {
    logic [N-1:0] io_in;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } qual_t;

  typedef struct {
    logic         safe;
    logic [N-1:0] oen;
    logic [N-1:0] out;
    logic [N-1:0] pen;
  } pad_t;

  logic                 clk;
  logic                 rst;
  logic [N-1:0]         pad_in;
  logic [N-1:0]         io_out;
  logic [N-1:0]         io_oe;
  logic [N-1:0][5:0]    pad_cfg;
  logic [N-1:0][1:0]    mode;
  logic [7:0]           thresh;
  logic [N-1:0]         io_in_o;
  logic [N-1:0]         rise_o;
  logic [N-1:0]         fall_o;
  logic [N-1:0]         pad_out_o;
  logic [N-1:0]         pad_oen_o;
  logic [N-1:0]         pad_pen_o;
  logic                 safe_o;

  qual_t        qq[$];
  pad_t         pq[$];
  logic [N-1:0] bq[$];

  int n_cmp = 0;
  int n_err = 0;

  io_pad_ctrl_gen #(
    .N_IO        (N),
    .NBIT_PADCFG (6),
    .SYNC_STAGES (2),
    .CNT_W       (8),
    .SAFE_CYCLES (16),
    .IN_RST_VAL  (ALL1)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pad_in_i      (pad_in),
    .io_out_i      (io_out),
    .io_oe_i       (io_oe),
    .pad_cfg_i     (pad_cfg),
    .filt_mode_i   (mode),
    .filt_thresh_i (thresh),
    .io_in_o       (io_in_o),
    .rise_o        (rise_o),
    .fall_o        (fall_o),
    .pad_out_o     (pad_out_o),
    .pad_oen_o     (pad_oen_o),
    .pad_pen_o     (pad_pen_o),
    .safe_o        (safe_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic pad_t pad_exp(input logic s);
    pad_t e;
    e.safe = s;
    e.oen  = s ? ALL1 : ~io_oe;
    e.out  = s ? '0 : io_out;
    for (int i = 0; i < N; i++) e.pen[i] = s ? 1'b0 : ~pad_cfg[i][0];
    return e;
  endfunction

  function automatic qual_t qual_exp(input logic [N-1:0] v, input logic [N-1:0] r,
                                     input logic [N-1:0] f);
    qual_t e;
    e.io_in = v;
    e.rise  = r;
    e.fall  = f;
    return e;
  endfunction

  task automatic test_reset();
    qual_t q;
    pad_t  p;
    pad_in = '0;
    repeat (2) tick();
    qq.push_back(qual_exp(ALL1, '0, '0));
    pq.push_back(pad_exp(1'b1));
    q = qq.pop_front();
    n_cmp++;
    if (io_in_o !== q.io_in || rise_o !== q.rise || fall_o !== q.fall) begin
      n_err++;
      $display("FAIL reset_qual io_in=%h rise=%h fall=%h required io_in=%h rise=%h fall=%h",
               io_in_o, rise_o, fall_o, q.io_in, q.rise, q.fall);
    end
    p = pq.pop_front();
    n_cmp++;
    if (safe_o !== p.safe || pad_oen_o !== p.oen || pad_out_o !== p.out || pad_pen_o !== p.pen) begin
      n_err++;
      $display("FAIL reset_pad safe=%b oen=%h out=%h pen=%h required safe=%b oen=%h out=%h pen=%h",
               safe_o, pad_oen_o, pad_out_o, pad_pen_o, p.safe, p.oen, p.out, p.pen);
    end
    pad_in = ALL1;
    repeat (3) tick();
  endtask

  task automatic test_safe_window();
    pad_t p;
    rst = 1'b0;
    #1;
    pq.push_back(pad_exp(1'b1));
    p = pq.pop_front();
    n_cmp++;
    if (safe_o !== p.safe || pad_oen_o !== p.oen || pad_out_o !== p.out || pad_pen_o !== p.pen) begin
      n_err++;
      $display("FAIL safe_release safe=%b oen=%h out=%h pen=%h required safe=%b oen=%h out=%h pen=%h",
               safe_o, pad_oen_o, pad_out_o, pad_pen_o, p.safe, p.oen, p.out, p.pen);
    end
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 17) begin
        io_oe  = 48'hF0F0_1234_ABCD;
        io_out = 48'h0F0F_5A5A_C3C3;
        #1;
      end
      pq.push_back(pad_exp(k < 16));
      p = pq.pop_front();
      n_cmp++;
      if (safe_o !== p.safe || pad_oen_o !== p.oen || pad_out_o !== p.out || pad_pen_o !== p.pen) begin
        n_err++;
        $display("FAIL safe_window tick%0d safe=%b oen=%h out=%h pen=%h required safe=%b oen=%h out=%h pen=%h",
                 k, safe_o, pad_oen_o, pad_out_o, pad_pen_o, p.safe, p.oen, p.out, p.pen);
      end
    end
  endtask

  task automatic test_sync_edge();
    qual_t q;
    for (int k = 1; k <= 4; k++)
      qq.push_back(qual_exp((k >= 2) ? ~B5 : ALL1, '0, (k == 2) ? B5 : '0));
    pad_in[5] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      q = qq.pop_front();
      n_cmp++;
      if (io_in_o !== q.io_in || rise_o !== q.rise || fall_o !== q.fall) begin
        n_err++;
        $display("FAIL sync_fall_ch5 tick%0d io_in=%h rise=%h fall=%h required io_in=%h rise=%h fall=%h",
                 k, io_in_o, rise_o, fall_o, q.io_in, q.rise, q.fall);
      end
    end
    for (int k = 1; k <= 4; k++)
      qq.push_back(qual_exp((k >= 2) ? ALL1 : ~B5, (k == 2) ? B5 : '0, '0));
    pad_in[5] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      q = qq.pop_front();
      n_cmp++;
      if (io_in_o !== q.io_in || rise_o !== q.rise || fall_o !== q.fall) begin
        n_err++;
        $display("FAIL sync_rise_ch5 tick%0d io_in=%h rise=%h fall=%h required io_in=%h rise=%h fall=%h",
                 k, io_in_o, rise_o, fall_o, q.io_in, q.rise, q.fall);
      end
    end
  endtask

  task automatic test_debounce();
    qual_t q;
    mode[7] = 2'b10;
    thresh  = 8'd3;
    // Glitch of three clocks is rejected; entering DEBOUNCE is silent.
    for (int k = 1; k <= 10; k++) qq.push_back(qual_exp(ALL1, '0, '0));
    for (int k = 1; k <= 10; k++) begin
      tick();
      q = qq.pop_front();
      n_cmp++;
      if (io_in_o !== q.io_in || rise_o !== q.rise || fall_o !== q.fall) begin
        n_err++;
        $display("FAIL deb_glitch tick%0d io_in=%h rise=%h fall=%h required io_in=%h rise=%h fall=%h",
                 k, io_in_o, rise_o, fall_o, q.io_in, q.rise, q.fall);
      end
      if (k == 2) pad_in[7] = 1'b0;
      if (k == 5) pad_in[7] = 1'b1;
    end
    // Low for four clocks: accepted at tick 6, then the return to high is
    // accepted four clocks later.
    for (int k = 1; k <= 11; k++)
      qq.push_back(qual_exp((k >= 6 && k <= 9) ? ~B7 : ALL1,
                            (k == 10) ? B7 : '0, (k == 6) ? B7 : '0));
    pad_in[7] = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      q = qq.pop_front();
      n_cmp++;
      if (io_in_o !== q.io_in || rise_o !== q.rise || fall_o !== q.fall) begin
        n_err++;
        $display("FAIL deb_hold tick%0d io_in=%h rise=%h fall=%h required io_in=%h rise=%h fall=%h",
                 k, io_in_o, rise_o, fall_o, q.io_in, q.rise, q.fall);
      end
      if (k == 4) pad_in[7] = 1'b1;
    end
  endtask

  task automatic test_thresh_lower();
    qual_t q;
    thresh = 8'd10;
    for (int k = 1; k <= 6; k++)
      qq.push_back(qual_exp((k >= 5) ? ~B7 : ALL1, '0, (k == 5) ? B7 : '0));
    pad_in[7] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      q = qq.pop_front();
      n_cmp++;
      if (io_in_o !== q.io_in || rise_o !== q.rise || fall_o !== q.fall) begin
        n_err++;
        $display("FAIL thresh_lower tick%0d io_in=%h rise=%h fall=%h required io_in=%h rise=%h fall=%h",
                 k, io_in_o, rise_o, fall_o, q.io_in, q.rise, q.fall);
      end
      if (k == 4) thresh = 8'd1;
    end
    thresh = 8'd0;
    for (int k = 1; k <= 4; k++)
      qq.push_back(qual_exp((k >= 3) ? ALL1 : ~B7, (k == 3) ? B7 : '0, '0));
    pad_in[7] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      q = qq.pop_front();
      n_cmp++;
      if (io_in_o !== q.io_in || rise_o !== q.rise || fall_o !== q.fall) begin
        n_err++;
        $display("FAIL thresh_zero tick%0d io_in=%h rise=%h fall=%h required io_in=%h rise=%h fall=%h",
                 k, io_in_o, rise_o, fall_o, q.io_in, q.rise, q.fall);
      end
    end
  endtask

  task automatic test_bypass();
    logic [N-1:0] e;
    logic         v;
    mode[0] = 2'b00;
    for (int k = 0; k < 8; k++) begin
      tick();
      v = (k % 2 == 1);
      pad_in[0] = v;
      bq.push_back(v ? ALL1 : ~B0);
      #1;
      e = bq.pop_front();
      n_cmp++;
      if (io_in_o !== e) begin
        n_err++;
        $display("FAIL bypass_ch0 step%0d io_in=%h required %h", k, io_in_o, e);
      end
    end
    pad_in[0] = 1'b1;
    repeat (4) tick();
    mode[0] = 2'b01;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    qual_t q;
    pad_t  p;
    thresh = 8'd5;
    pad_in[7] = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    qq.push_back(qual_exp(ALL1, '0, '0));
    pq.push_back(pad_exp(1'b1));
    q = qq.pop_front();
    n_cmp++;
    if (io_in_o !== q.io_in || rise_o !== q.rise || fall_o !== q.fall) begin
      n_err++;
      $display("FAIL rst_mid_deb io_in=%h rise=%h fall=%h required io_in=%h rise=%h fall=%h",
               io_in_o, rise_o, fall_o, q.io_in, q.rise, q.fall);
    end
    p = pq.pop_front();
    n_cmp++;
    if (safe_o !== p.safe || pad_oen_o !== p.oen || pad_out_o !== p.out || pad_pen_o !== p.pen) begin
      n_err++;
      $display("FAIL rst_mid_pad safe=%b oen=%h out=%h pen=%h required safe=%b oen=%h out=%h pen=%h",
               safe_o, pad_oen_o, pad_out_o, pad_pen_o, p.safe, p.oen, p.out, p.pen);
    end
    repeat (2) tick();
    rst = 1'b0;
    // The aborted count restarts from zero: sync needs 2 clocks, then 6.
    for (int k = 1; k <= 9; k++) begin
      qq.push_back(qual_exp((k >= 8) ? ~B7 : ALL1, '0, (k == 8) ? B7 : '0));
      pq.push_back(pad_exp(1'b1));
    end
    for (int k = 1; k <= 9; k++) begin
      tick();
      q = qq.pop_front();
      n_cmp++;
      if (io_in_o !== q.io_in || rise_o !== q.rise || fall_o !== q.fall) begin
        n_err++;
        $display("FAIL rst_recount tick%0d io_in=%h rise=%h fall=%h required io_in=%h rise=%h fall=%h",
                 k, io_in_o, rise_o, fall_o, q.io_in, q.rise, q.fall);
      end
      p = pq.pop_front();
      n_cmp++;
      if (safe_o !== p.safe || pad_oen_o !== p.oen) begin
        n_err++;
        $display("FAIL rst_window tick%0d safe=%b oen=%h required safe=%b oen=%h",
                 k, safe_o, pad_oen_o, p.safe, p.oen);
      end
    end
    // Second reset inside the window restarts it.
    tick();
    rst = 1'b1;
    #1;
    qq.push_back(qual_exp(ALL1, '0, '0));
    q = qq.pop_front();
    n_cmp++;
    if (io_in_o !== q.io_in || rise_o !== q.rise || fall_o !== q.fall) begin
      n_err++;
      $display("FAIL rst_in_window io_in=%h rise=%h fall=%h required io_in=%h rise=%h fall=%h",
               io_in_o, rise_o, fall_o, q.io_in, q.rise, q.fall);
    end
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 17; k++) pq.push_back(pad_exp(k < 16));
    for (int k = 1; k <= 17; k++) begin
      tick();
      p = pq.pop_front();
      n_cmp++;
      if (safe_o !== p.safe || pad_oen_o !== p.oen || pad_out_o !== p.out || pad_pen_o !== p.pen) begin
        n_err++;
        $display("FAIL rst_restart tick%0d safe=%b oen=%h out=%h pen=%h required safe=%b oen=%h out=%h pen=%h",
                 k, safe_o, pad_oen_o, pad_out_o, pad_pen_o, p.safe, p.oen, p.out, p.pen);
      end
    end
    pad_in[7] = 1'b1;
  endtask

  initial begin
    rst    = 1'b0;
    pad_in = ALL1;
    io_out = 48'hA5A5_5A5A_3C3C;
    io_oe  = ALL1;
    thresh = 8'd3;
    for (int i = 0; i < N; i++) begin
      mode[i]    = 2'b01;
      pad_cfg[i] = 6'((i * 7 + 3) % 64);
    end
    #2;
    rst = 1'b1;
    test_reset();
    test_safe_window();
    test_sync_edge();
    test_debounce();
    test_thresh_lower();
    test_bypass();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
